// File: rtl/bcd_counter_mux.sv
// rtl/bcd_counter_mux.sv - parametrised BCD up/down counter with hold snapshot and BCD/Gray pair readout
module bcd_counter_mux #(
    parameter int DIGITS = 12,
    parameter int SEL_W  = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic                  i_up,
    input  logic                  i_load,
    input  logic [4*DIGITS-1:0]   i_init,
    input  logic                  i_hold,
    input  logic [SEL_W:0]        i_sel,
    output logic [7:0]            o_cnt,
    output logic                  o_wrap,
    output logic                  o_zero
);
    localparam int W = 4 * DIGITS;

    logic [W-1:0]     cnt;
    logic [W-1:0]     snap;
    logic [W-1:0]     cnt_step;
    logic [W-1:0]     cnt_load;
    logic [W-1:0]     cnt_next;
    logic             carry;
    logic             wrap_next;
    logic [3:0]       step_d;
    logic [3:0]       load_d;
    logic [3:0]       lo;
    logic [3:0]       hi;
    logic [SEL_W-1:0] pair;
    logic             gray;

    // Ripple the carry/borrow through every digit; a carry out of the top digit is a full wrap.
    always_comb begin
        cnt_step = cnt;
        carry    = 1'b1;
        step_d   = 4'd0;
        for (int k = 0; k < DIGITS; k++) begin
            step_d = cnt[4*k +: 4];
            if (carry) begin
                if (i_up) begin
                    if (step_d >= 4'd9) begin
                        cnt_step[4*k +: 4] = 4'd0;
                    end else begin
                        cnt_step[4*k +: 4] = step_d + 4'd1;
                        carry = 1'b0;
                    end
                end else begin
                    if (step_d == 4'd0) begin
                        cnt_step[4*k +: 4] = 4'd9;
                    end else begin
                        cnt_step[4*k +: 4] = step_d - 4'd1;
                        carry = 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        cnt_load = '0;
        load_d   = 4'd0;
        for (int k = 0; k < DIGITS; k++) begin
            load_d = i_init[4*k +: 4];
            cnt_load[4*k +: 4] = (load_d > 4'd9) ? 4'd9 : load_d;
        end
    end

    always_comb begin
        cnt_next  = cnt;
        wrap_next = 1'b0;
        if (i_load) begin
            cnt_next = cnt_load;
        end else if (i_en) begin
            cnt_next  = cnt_step;
            wrap_next = carry;
        end
    end

    // snap follows the next count so an unheld readout shows the value from the same edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt    <= '0;
            snap   <= '0;
            o_wrap <= 1'b0;
        end else begin
            cnt    <= cnt_next;
            o_wrap <= wrap_next;
            if (!i_hold) begin
                snap <= cnt_next;
            end
        end
    end

    assign pair = i_sel[SEL_W-1:0];
    assign gray = i_sel[SEL_W];

    always_comb begin
        lo = 4'd0;
        hi = 4'd0;
        for (int k = 0; k < DIGITS; k++) begin
            if (k == 2 * int'(pair)) begin
                lo = snap[4*k +: 4];
            end
            if (k == 2 * int'(pair) + 1) begin
                hi = snap[4*k +: 4];
            end
        end
    end

    assign o_cnt  = gray ? {hi ^ (hi >> 1), lo ^ (lo >> 1)} : {hi, lo};
    assign o_zero = (cnt == '0);
endmodule

// File: tb/tb_bcd_counter_mux.sv
// tb/tb_bcd_counter_mux.sv - directed scoreboard bench for bcd_counter_mux
module tb_bcd_counter_mux;
    localparam int DIGITS = 12;
    localparam int SEL_W  = 5;

    logic                i_clk = 1'b0;
    logic                i_rst;
    logic                i_en;
    logic                i_up;
    logic                i_load;
    logic [4*DIGITS-1:0] i_init;
    logic                i_hold;
    logic [SEL_W:0]      i_sel;
    logic [7:0]          o_cnt;
    logic                o_wrap;
    logic                o_zero;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    bcd_counter_mux #(.DIGITS(DIGITS), .SEL_W(SEL_W)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_en  (i_en),
        .i_up  (i_up),
        .i_load(i_load),
        .i_init(i_init),
        .i_hold(i_hold),
        .i_sel (i_sel),
        .o_cnt (o_cnt),
        .o_wrap(o_wrap),
        .o_zero(o_zero)
    );

    always #5 i_clk = ~i_clk;

    task automatic push(input logic [7:0] v);
        exp_q.push_back(v);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs);
        logic [7:0] exp_v;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s observed=%02h expected=<empty scoreboard>", tag, obs);
        end else begin
            exp_v = exp_q.pop_front();
            assert (obs === exp_v) else begin
                errors++;
                $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp_v);
            end
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [SEL_W:0] sel, input logic [7:0] exp_v);
        push(exp_v);
        i_sel = sel;
        #1;
        chk(tag, o_cnt);
    endtask

    initial begin
        i_rst = 1'b1; i_en = 1'b0; i_up = 1'b1; i_load = 1'b0;
        i_init = '0; i_hold = 1'b0; i_sel = '0;
        #2;
        rd("rst_p0", 6'h00, 8'h00);
        rd("rst_gray_p5", 6'h25, 8'h00);
        push(8'h01); chk("rst_zero", {7'd0, o_zero});
        push(8'h00); chk("rst_wrap", {7'd0, o_wrap});
        @(negedge i_clk);
        i_rst = 1'b0;
        step();

        // 123 enabled increments
        i_en = 1'b1; i_up = 1'b1;
        repeat (123) step();
        i_en = 1'b0;
        rd("cnt123_p0", 6'h00, 8'h23);
        rd("cnt123_p1", 6'h01, 8'h01);
        push(8'h00); chk("cnt123_zero", {7'd0, o_zero});

        // full wrap up
        i_load = 1'b1; i_init = 48'h9999_9999_9999;
        step();
        i_load = 1'b0;
        rd("all9_p3", 6'h03, 8'h99);
        push(8'h00); chk("load_no_wrap", {7'd0, o_wrap});
        i_en = 1'b1; i_up = 1'b1;
        step();
        i_en = 1'b0;
        push(8'h01); chk("wrap_up_pulse", {7'd0, o_wrap});
        for (int p = 0; p < 6; p++) rd("wrap_up_pair", 6'(p), 8'h00);
        push(8'h01); chk("wrap_up_zero", {7'd0, o_zero});
        step();
        push(8'h00); chk("wrap_up_fall", {7'd0, o_wrap});

        // borrow chain
        i_load = 1'b1; i_init = 48'h1000;
        step();
        i_load = 1'b0; i_en = 1'b1; i_up = 1'b0;
        step();
        i_en = 1'b0;
        rd("borrow_p0", 6'h00, 8'h99);
        rd("borrow_p1", 6'h01, 8'h09);
        rd("borrow_p2", 6'h02, 8'h00);
        push(8'h00); chk("borrow_no_wrap", {7'd0, o_wrap});
        i_load = 1'b1; i_init = '0;
        step();
        i_load = 1'b0; i_en = 1'b1;
        step();
        i_en = 1'b0;
        push(8'h01); chk("wrap_dn_pulse", {7'd0, o_wrap});
        rd("wrap_dn_p5", 6'h05, 8'h99);
        rd("wrap_dn_p0", 6'h00, 8'h99);
        rd("oob_pair7", 6'h07, 8'h00);
        push(8'h00); chk("wrap_dn_zero", {7'd0, o_zero});
        step();
        push(8'h00); chk("wrap_dn_fall", {7'd0, o_wrap});

        // clamp and Gray
        i_load = 1'b1; i_init = 48'h7F;
        step();
        i_load = 1'b0;
        rd("clamp_bcd", 6'h00, 8'h79);
        rd("clamp_gray", 6'h20, 8'h4D);

        // hold coherence
        i_load = 1'b1; i_init = '0;
        step();
        i_load = 1'b0; i_en = 1'b1; i_up = 1'b1;
        repeat (42) step();
        rd("pre_hold", 6'h00, 8'h42);
        i_hold = 1'b1;
        repeat (9) step();
        rd("hold_frozen", 6'h00, 8'h42);
        push(8'h00); chk("hold_zero_live", {7'd0, o_zero});
        i_hold = 1'b0;
        step();
        rd("hold_release", 6'h00, 8'h52);
        i_en = 1'b0;

        // load beats enable, then async reset kills a pending wrap
        i_load = 1'b1; i_en = 1'b1; i_init = 48'h555;
        step();
        rd("prio_p0", 6'h00, 8'h55);
        rd("prio_p1", 6'h01, 8'h05);
        i_init = 48'h9999_9999_9999;
        step();
        push(8'h00); chk("prio_no_wrap", {7'd0, o_wrap});
        rd("prio_all9", 6'h02, 8'h99);
        i_load = 1'b0;
        step();
        push(8'h01); chk("pend_wrap", {7'd0, o_wrap});
        #1;
        i_rst = 1'b1;
        #1;
        rd("async_rst_cnt", 6'h00, 8'h00);
        push(8'h00); chk("async_rst_wrap", {7'd0, o_wrap});
        push(8'h01); chk("async_rst_zero", {7'd0, o_zero});
        i_en = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
